// File: rtl/serializer_pkg.sv
// Shared types and helpers for the bit serializer.
// Optional parity support is compiled in with SERIALIZER_PARITY_EN.
package serializer_pkg;

`ifdef SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SHIFT  = 2'b01,
        ST_PARITY = 2'b10
    } ser_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01
    } ser_state_t;
`endif

    // Bits needed to hold a bit index 0..width-1 (at least one bit).
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// Loadable WIDTH-bit shift register with fixed direction.
// Ports: clk, rst (sync, active-high), load/shift controls, din word;
//   first_bit = bit of din that goes out first,
//   next_bit  = bit presented after the next shift.
module ser_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             first_bit,
    output logic             next_bit
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            if (MSB_FIRST)
                sr <= {sr[WIDTH-2:0], 1'b0};
            else
                sr <= {1'b0, sr[WIDTH-1:1]};
        end
    end

    // The head bit is already on the output register, so the
    // serializer always needs the bit one position behind it.
    assign first_bit = MSB_FIRST ? din[WIDTH-1] : din[0];
    assign next_bit  = MSB_FIRST ? sr[WIDTH-2]  : sr[1];

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: valid/ready word in, one bit per clock out.
// Ports: clk, rst (sync, active-high), s_data/s_valid/s_ready handshake,
//   bit_out/bit_valid serial stream, word_done last-bit pulse, busy.
// Define SERIALIZER_PARITY_EN to append an even parity bit per word.
module bit_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    ser_state_t      state;
    ser_state_t      state_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic            bit_q;
    logic            bit_n;
    logic            accept;
    logic            sr_shift;
    logic            first_bit;
    logic            next_bit;
    logic            last_payload;
    logic            word_last;

`ifdef SERIALIZER_PARITY_EN
    logic            par_q;
    logic            par_n;
`endif

    ser_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_sr (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .shift     (sr_shift),
        .din       (s_data),
        .first_bit (first_bit),
        .next_bit  (next_bit)
    );

    assign last_payload = (state == ST_SHIFT) && (cnt == '0);

    // The final bit of a word is on the line this cycle; a new word
    // may be accepted now so the next one follows with no gap.
`ifdef SERIALIZER_PARITY_EN
    assign word_last = (state == ST_PARITY);
`else
    assign word_last = last_payload;
`endif

    assign s_ready   = !rst && ((state == ST_IDLE) || word_last);
    assign accept    = s_valid && s_ready;
    assign word_done = word_last;
    assign bit_out   = bit_q;
    assign bit_valid = (state != ST_IDLE);
    assign busy      = (state != ST_IDLE);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bit_n    = 1'b0;
        sr_shift = 1'b0;
`ifdef SERIALIZER_PARITY_EN
        par_n    = par_q;
`endif
        unique case (state)
            ST_IDLE: begin
                state_n = ST_IDLE;
            end
            ST_SHIFT: begin
                if (cnt != '0) begin
                    cnt_n    = cnt - 1'b1;
                    bit_n    = next_bit;
                    sr_shift = 1'b1;
                end else begin
`ifdef SERIALIZER_PARITY_EN
                    state_n = ST_PARITY;
                    bit_n   = par_q;
`else
                    state_n = ST_IDLE;
`endif
                end
            end
`ifdef SERIALIZER_PARITY_EN
            ST_PARITY: begin
                state_n = ST_IDLE;
            end
`endif
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // A new word overrides the end-of-word decision above.
        if (accept) begin
            state_n = ST_SHIFT;
            cnt_n   = CNT_LAST;
            bit_n   = first_bit;
`ifdef SERIALIZER_PARITY_EN
            par_n   = ^s_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            bit_q <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            par_q <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            bit_q <= bit_n;
`ifdef SERIALIZER_PARITY_EN
            par_q <= par_n;
`endif
        end
    end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the serial sequence-detector path. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a qualified serial output that drives the detector's `in` input directly. Holds the line at 0 when idle, so the detector sees a defined stream. An optional parity bit can be appended per word.

## Interface
- `WIDTH`, 8, word width in bits, ≥2
- `MSB_FIRST`, 1, 1: transmit bit WIDTH-1 first; 0: bit 0 first
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `s_data`  in  WIDTH  parallel word
- `s_valid`  in  1  `s_data` valid
- `s_ready`  out  1  block can accept a word this cycle (combinational from state/counter)
- `bit_out`  out  1  serial bit, registered; 0 whenever `bit_valid`=0
- `bit_valid`  out  1  `bit_out` carries a payload or parity bit
- `word_done`  out  1  one-cycle pulse coincident with the last bit of a word (parity bit if enabled)
- `busy`  out  1  state ≠ IDLE

## Operation
- States: IDLE, SHIFT, PARITY (PARITY exists only with `SERIALIZER_PARITY_EN`).
- Accept occurs when `s_valid && s_ready` at a clock edge.
- On accept: load shift register with `s_data`, set counter=WIDTH-1, go to SHIFT, and register the first bit onto `bit_out`.
- `s_ready`=1 in IDLE, and on the cycle the final bit of the current word is presented (SHIFT with counter=0 and no parity, or PARITY). Otherwise 0. `s_ready`=0 while `rst`=1.
- SHIFT: each cycle present the next bit, shifting in the MSB_FIRST direction, and decrement the counter.
- After the last payload bit:
  - parity enabled → PARITY;
  - else → SHIFT again if a new word is accepted, else IDLE.
- PARITY: present even parity (XOR of the accepted word). Then go to SHIFT on accept, else IDLE.
- Back-to-back words stream with no gap cycle.
- `s_data` is sampled only at accept; later changes are ignored.
- `word_done` pulses with the final bit (last payload bit, or the parity bit when enabled).

## Timing
- Accept at edge N → first bit valid in cycle N+1 and last payload bit in N+WIDTH.
- With parity enabled, the parity bit follows in N+WIDTH+1.
- Throughput: one word per WIDTH cycles (WIDTH+1 with parity).
- Reset values: `bit_out`=0, `bit_valid`=0, `word_done`=0, `busy`=0, state IDLE, counter 0.
- Reset mid-word: the word is abandoned, nothing further is emitted, and `bit_valid`=0 from the cycle after the reset edge.
- `s_valid` low at end of word: `bit_valid` falls next cycle and `bit_out` returns to 0.
- `s_valid` with `s_ready`=0: no accept; the upstream must hold the word.

## Configuration
- `SERIALIZER_PARITY_EN` defined:
  - PARITY state and parity register compiled in;
  - each word is WIDTH+1 serial bits;
  - `word_done` pulses on the parity bit.
- Undefined:
  - no PARITY state;
  - each word is exactly WIDTH bits;
  - `word_done` pulses on the last payload bit.

## Structure
- Package `serializer_pkg`:
  - state encoding localparams/typedef (IDLE=2'b00, SHIFT=2'b01, PARITY=2'b10);
  - counter-width function (clog2 of WIDTH).
- Sub-module `ser_shift_reg`: loadable WIDTH-bit shift register with direction select, outputting the current bit. The FSM, counter, handshake and parity stay in `bit_serializer`.

## Test plan
- WIDTH=8, MSB_FIRST=1, accept 0xA5 at N → `bit_out` 1,0,1,0,0,1,0,1 in N+1..N+8, `word_done` at N+8, `bit_valid`=0 at N+9.
- Words 0xA5 then 0x3C with `s_valid` held → 16 contiguous valid bits, `s_ready`=1 only in IDLE and in cycles N+8 and N+16, two `word_done` pulses.
- MSB_FIRST=0, word 0x01 → 1 followed by seven 0s.
- `SERIALIZER_PARITY_EN`:
  - 0xA5 → nine bits, ninth = 0;
  - 0xA4 → ninth = 1;
  - `word_done` on the ninth bit.
- `rst` asserted during the third bit of 0xFF → next cycle `bit_valid`=0, `bit_out`=0, `busy`=0; after release, the next word starts cleanly.
- Chained with the "101" Mealy detector, word 0x05 MSB-first → detector `out` pulses exactly once, on the final bit.
